// File: rtl/id_alloc_if.sv
// Allocation/retire port bundle for id_alloc_scheduler.
// The master side is the requester and retire agent; the slave side is the scheduler.
interface id_alloc_if #(
   parameter int MAX_IDS = 8,
   parameter int ID_W    = $clog2(MAX_IDS)
);
   logic            flush;
   logic            alloc_valid;
   logic [ID_W-1:0] alloc_id;
   logic            alloc_take;
   logic            retire_valid;
   logic [ID_W-1:0] retire_id;
   logic            issue_toggle;
   logic [ID_W-1:0] issue_toggle_id;
   logic            retire_toggle;
   logic [ID_W-1:0] retire_toggle_id;
   logic [ID_W:0]   inflight_count;
   logic            idle;
   logic            retire_err;

   modport master (
      output flush, alloc_take, retire_valid, retire_id,
      input  alloc_valid, alloc_id, issue_toggle, issue_toggle_id,
             retire_toggle, retire_toggle_id, inflight_count, idle, retire_err
   );

   modport slave (
      input  flush, alloc_take, retire_valid, retire_id,
      output alloc_valid, alloc_id, issue_toggle, issue_toggle_id,
             retire_toggle, retire_toggle_id, inflight_count, idle, retire_err
   );
endinterface

// File: rtl/id_alloc_scheduler.sv
// Instruction-ID allocator: circular free list plus in-flight bitmap. INIT rebuilds
// the free list one ID per cycle and reclaims any ID still marked in flight.
module id_alloc_scheduler #(
   parameter int MAX_IDS = 8,
   parameter int ID_W    = $clog2(MAX_IDS)
) (
   input logic        clk,
   input logic        rst,
   id_alloc_if.slave  bus
);
   localparam logic [ID_W:0]   FULL = (ID_W+1)'(MAX_IDS);
   localparam logic [ID_W-1:0] LAST = ID_W'(MAX_IDS - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t             state_reg, state_next;
   logic [ID_W-1:0]    idx_reg, head_reg, tail_reg;
   logic [ID_W:0]      free_cnt_reg;
   logic [MAX_IDS-1:0] inflight_reg;
   logic               err_reg;
   logic [ID_W-1:0]    free_mem [MAX_IDS];

   logic               run_act;
   logic               alloc_fire, retire_fire, retire_drop, init_reclaim;
   logic               push_en;
   logic [ID_W-1:0]    push_id, head_id;
   logic               retire_tog;
   logic [ID_W-1:0]    retire_tog_id;
   logic [MAX_IDS-1:0] set_vec, clr_vec;

   assign head_id = free_mem[head_reg];
   assign run_act = (state_reg == RUN) && !rst;

   always_comb begin
      state_next   = state_reg;
      alloc_fire   = 1'b0;
      retire_fire  = 1'b0;
      retire_drop  = 1'b0;
      init_reclaim = 1'b0;
      push_en      = 1'b0;
      push_id      = bus.retire_id;
      if (!rst) begin
         case (state_reg)
            INIT: begin
               push_en      = 1'b1;
               push_id      = idx_reg;
               init_reclaim = inflight_reg[idx_reg];
               if (idx_reg == LAST)
                  state_next = RUN;
            end
            RUN: begin
               if (bus.flush) begin
                  state_next = INIT;
               end else begin
                  alloc_fire = bus.alloc_take && (free_cnt_reg != '0);
                  // An ID being handed out this cycle is not yet in flight.
                  if (bus.retire_valid) begin
                     if (inflight_reg[bus.retire_id] &&
                         !(alloc_fire && (bus.retire_id == head_id)))
                        retire_fire = 1'b1;
                     else
                        retire_drop = 1'b1;
                  end
                  push_en = retire_fire;
               end
            end
            default: state_next = INIT;
         endcase
      end
   end

   assign retire_tog    = retire_fire || init_reclaim;
   assign retire_tog_id = init_reclaim ? idx_reg : bus.retire_id;

   assign bus.alloc_valid      = run_act && (free_cnt_reg != '0);
   assign bus.alloc_id         = head_id;
   assign bus.issue_toggle     = alloc_fire;
   assign bus.issue_toggle_id  = head_id;
   assign bus.retire_toggle    = retire_tog;
   assign bus.retire_toggle_id = retire_tog_id;
   assign bus.inflight_count   = run_act ? (FULL - free_cnt_reg) : '0;
   assign bus.idle             = run_act && (free_cnt_reg == FULL);
   assign bus.retire_err       = err_reg;

   genvar gi;
   generate
      for (gi = 0; gi < MAX_IDS; gi++) begin : g_bit
         assign set_vec[gi] = alloc_fire && (head_id == ID_W'(gi));
         assign clr_vec[gi] = retire_tog && (retire_tog_id == ID_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= INIT;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg      <= '0;
         head_reg     <= '0;
         tail_reg     <= '0;
         free_cnt_reg <= '0;
         inflight_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         inflight_reg <= (inflight_reg & ~clr_vec) | set_vec;
         if (state_reg == INIT) begin
            idx_reg      <= idx_reg + ID_W'(1);
            tail_reg     <= tail_reg + ID_W'(1);
            free_cnt_reg <= free_cnt_reg + (ID_W+1)'(1);
         end else if (bus.flush) begin
            idx_reg      <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            free_cnt_reg <= '0;
         end else begin
            head_reg     <= head_reg + ID_W'(alloc_fire);
            tail_reg     <= tail_reg + ID_W'(retire_fire);
            free_cnt_reg <= free_cnt_reg + (ID_W+1)'(retire_fire) - (ID_W+1)'(alloc_fire);
            err_reg      <= err_reg || retire_drop;
         end
      end
   end

   // Storage only; validity is tracked by the pointers, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_en)
         free_mem[tail_reg] <= push_id;
   end
endmodule

// File: tb/tb_id_alloc_scheduler.sv
// Scoreboard bench for id_alloc_scheduler: expected toggle IDs are queued when
// stimulus is driven and checked by a monitor when the DUT emits them.
module tb_id_alloc_scheduler;
   localparam int MAX_IDS = 8;
   localparam int ID_W    = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   id_alloc_if #(.MAX_IDS(MAX_IDS)) bus ();

   id_alloc_scheduler #(.MAX_IDS(MAX_IDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int issue_q[$];
   int retire_q[$];
   int exp_free[$];
   bit exp_infl[MAX_IDS];
   int mon_e;

   // Monitor: every toggle must match the head of its scoreboard queue.
   always @(negedge clk) begin
      if (bus.issue_toggle === 1'b1) begin
         tests_run++;
         if (issue_q.size() == 0) begin
            tests_failed++;
            $display("FAIL issue_unexpected: got id %0d, required no issue_toggle", bus.issue_toggle_id);
         end else begin
            mon_e = issue_q.pop_front();
            if (bus.issue_toggle_id !== ID_W'(mon_e)) begin
               tests_failed++;
               $display("FAIL issue_id: got %0d, required %0d", bus.issue_toggle_id, mon_e);
            end
         end
      end
      if (bus.retire_toggle === 1'b1) begin
         tests_run++;
         if (retire_q.size() == 0) begin
            tests_failed++;
            $display("FAIL retire_unexpected: got id %0d, required no retire_toggle", bus.retire_toggle_id);
         end else begin
            mon_e = retire_q.pop_front();
            if (bus.retire_toggle_id !== ID_W'(mon_e)) begin
               tests_failed++;
               $display("FAIL retire_id: got %0d, required %0d", bus.retire_toggle_id, mon_e);
            end
         end
      end
      if (bus.issue_toggle === 1'b1 && bus.retire_toggle === 1'b1) begin
         tests_run++;
         if (bus.issue_toggle_id === bus.retire_toggle_id) begin
            tests_failed++;
            $display("FAIL toggle_same_id: both toggles on id %0d, required distinct", bus.issue_toggle_id);
         end
      end
   end

   task automatic model_clear();
      exp_free.delete();
      for (int k = 0; k < MAX_IDS; k++) begin
         exp_free.push_back(k);
         exp_infl[k] = 1'b0;
      end
   endtask

   // One RUN-state cycle: predict, queue expected toggles, clock, update the model.
   task automatic drive(input bit take, input bit rv, input int rid);
      bit a, r;
      int aid;
      a   = take && (exp_free.size() > 0);
      aid = a ? exp_free[0] : 0;
      r   = rv && exp_infl[rid] && !(a && aid == rid);
      bus.alloc_take   = take;
      bus.retire_valid = rv;
      bus.retire_id    = ID_W'(rid);
      if (a) issue_q.push_back(aid);
      if (r) retire_q.push_back(rid);
      @(posedge clk);
      if (a) begin
         void'(exp_free.pop_front());
         exp_infl[aid] = 1'b1;
      end
      if (r) begin
         exp_free.push_back(rid);
         exp_infl[rid] = 1'b0;
      end
      $display("[TB] txn take=%0b alloc=%0b id=%0d retire=%0b id=%0d accepted=%0b", take, a, aid, rv, rid, r);
      #1;
      bus.alloc_take   = 1'b0;
      bus.retire_valid = 1'b0;
      bus.retire_id    = '0;
      #1;
   endtask

   // Flush plus the 8-cycle INIT walk; records which steps raised retire_toggle.
   task automatic run_flush(input bit take, input bit rv, input int rid,
                            output bit [MAX_IDS-1:0] obs, output bit any_valid);
      bus.flush        = 1'b1;
      bus.alloc_take   = take;
      bus.retire_valid = rv;
      bus.retire_id    = ID_W'(rid);
      @(posedge clk);
      #1;
      bus.flush        = 1'b0;
      bus.alloc_take   = 1'b0;
      bus.retire_valid = 1'b0;
      for (int k = 0; k < MAX_IDS; k++)
         if (exp_infl[k]) retire_q.push_back(k);
      model_clear();
      obs       = '0;
      any_valid = 1'b0;
      for (int k = 0; k < MAX_IDS; k++) begin
         @(negedge clk);
         obs[k] = bus.retire_toggle;
         if (bus.alloc_valid !== 1'b0) any_valid = 1'b1;
         @(posedge clk);
      end
      #2;
      $display("[TB] txn flush take=%0b retire=%0b id=%0d reclaimed=%b", take, rv, rid, obs);
   endtask

   task automatic test_reset();
      bit any_valid;
      rst = 1'b1;
      bus.flush = 1'b1;
      bus.alloc_take = 1'b1;
      bus.retire_valid = 1'b0;
      bus.retire_id = '0;
      repeat (2) @(posedge clk);
      #2;
      tests_run++;
      if (bus.alloc_valid !== 1'b0 || bus.idle !== 1'b0 || bus.inflight_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got valid=%b idle=%b count=%0d, required 0/0/0", bus.alloc_valid, bus.idle, bus.inflight_count);
      end
      tests_run++;
      if (bus.retire_err !== 1'b0 || bus.issue_toggle !== 1'b0 || bus.retire_toggle !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got err=%b itog=%b rtog=%b, required 0/0/0", bus.retire_err, bus.issue_toggle, bus.retire_toggle);
      end
      rst = 1'b0;
      bus.flush = 1'b0;
      bus.alloc_take = 1'b0;
      model_clear();
      any_valid = 1'b0;
      for (int c = 0; c < MAX_IDS; c++) begin
         @(negedge clk);
         if (bus.alloc_valid !== 1'b0) any_valid = 1'b1;
         @(posedge clk);
      end
      #2;
      tests_run++;
      if (any_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL init_alloc_valid: got alloc_valid=1 during INIT, required 0");
      end
      tests_run++;
      if (bus.alloc_valid !== 1'b1 || bus.alloc_id !== 3'd0 || bus.idle !== 1'b1) begin
         tests_failed++;
         $display("FAIL init_done: got valid=%b id=%0d idle=%b, required 1/0/1", bus.alloc_valid, bus.alloc_id, bus.idle);
      end
   endtask

   task automatic test_fill();
      for (int c = 0; c < MAX_IDS + 1; c++) drive(1'b1, 1'b0, 0);
      tests_run++;
      if (bus.alloc_valid !== 1'b0 || bus.inflight_count !== 4'd8 || bus.idle !== 1'b0) begin
         tests_failed++;
         $display("FAIL fill: got valid=%b count=%0d idle=%b, required 0/8/0", bus.alloc_valid, bus.inflight_count, bus.idle);
      end
      tests_run++;
      if (issue_q.size() != 0) begin
         tests_failed++;
         $display("FAIL fill_issues: got %0d pending issue toggles, required 0", issue_q.size());
      end
   endtask

   task automatic test_retire_empty();
      drive(1'b0, 1'b1, 5);
      tests_run++;
      if (bus.alloc_valid !== 1'b1 || bus.alloc_id !== 3'd5 || bus.inflight_count !== 4'd7) begin
         tests_failed++;
         $display("FAIL retire_empty: got valid=%b id=%0d count=%0d, required 1/5/7", bus.alloc_valid, bus.alloc_id, bus.inflight_count);
      end
   endtask

   task automatic test_simultaneous();
      drive(1'b1, 1'b0, 0);
      drive(1'b0, 1'b1, 3);
      drive(1'b1, 1'b1, 2);
      tests_run++;
      if (bus.inflight_count !== 4'd7 || bus.alloc_id !== 3'd2) begin
         tests_failed++;
         $display("FAIL simul_count: got count=%0d head=%0d, required 7/2", bus.inflight_count, bus.alloc_id);
      end
      drive(1'b0, 1'b1, 6);
      drive(1'b0, 1'b1, 6);
      tests_run++;
      if (bus.retire_err !== 1'b1 || bus.inflight_count !== 4'd6) begin
         tests_failed++;
         $display("FAIL free_retire: got err=%b count=%0d, required 1/6", bus.retire_err, bus.inflight_count);
      end
      drive(1'b1, 1'b1, 2);
      repeat (3) @(posedge clk);
      #2;
      tests_run++;
      if (bus.retire_err !== 1'b1 || bus.inflight_count !== 4'd7 || bus.alloc_id !== 3'd6) begin
         tests_failed++;
         $display("FAIL alloc_self_retire: got err=%b count=%0d head=%0d, required 1/7/6", bus.retire_err, bus.inflight_count, bus.alloc_id);
      end
   endtask

   task automatic test_flush();
      bit [MAX_IDS-1:0] obs, want;
      bit any_valid;
      for (int k = 0; k < MAX_IDS; k++) want[k] = exp_infl[k];
      run_flush(1'b0, 1'b0, 0, obs, any_valid);
      tests_run++;
      if (obs !== want) begin
         tests_failed++;
         $display("FAIL flush_reclaim_all: got steps %b, required %b", obs, want);
      end
      for (int c = 0; c < 5; c++) drive(1'b1, 1'b0, 0);
      drive(1'b0, 1'b1, 0);
      drive(1'b0, 1'b1, 2);
      drive(1'b0, 1'b1, 3);
      tests_run++;
      if (bus.inflight_count !== 4'd2) begin
         tests_failed++;
         $display("FAIL pre_flush_count: got %0d, required 2", bus.inflight_count);
      end
      run_flush(1'b1, 1'b1, 1, obs, any_valid);
      tests_run++;
      if (obs !== 8'b0001_0010 || any_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_steps: got steps %b valid_in_init=%b, required 00010010/0", obs, any_valid);
      end
      tests_run++;
      if (bus.alloc_valid !== 1'b1 || bus.alloc_id !== 3'd0 || bus.inflight_count !== 4'd0 || bus.idle !== 1'b1) begin
         tests_failed++;
         $display("FAIL post_flush: got valid=%b id=%0d count=%0d idle=%b, required 1/0/0/1", bus.alloc_valid, bus.alloc_id, bus.inflight_count, bus.idle);
      end
      tests_run++;
      if (retire_q.size() != 0 || issue_q.size() != 0) begin
         tests_failed++;
         $display("FAIL flush_queues: got %0d retire / %0d issue pending, required 0/0", retire_q.size(), issue_q.size());
      end
   endtask

   task automatic test_wrap();
      int pend[$];
      int aid, rid;
      bit rv;
      drive(1'b1, 1'b0, 0);
      drive(1'b1, 1'b0, 0);
      // Reset in the middle of traffic: no toggles may follow from the stale IDs.
      rst = 1'b1;
      bus.flush = 1'b1;
      bus.alloc_take = 1'b1;
      bus.retire_valid = 1'b1;
      bus.retire_id = 3'd1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.flush = 1'b0;
      bus.alloc_take = 1'b0;
      bus.retire_valid = 1'b0;
      model_clear();
      repeat (MAX_IDS) @(posedge clk);
      #2;
      tests_run++;
      if (bus.alloc_valid !== 1'b1 || bus.retire_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL rerun_reset: got valid=%b err=%b, required 1/0", bus.alloc_valid, bus.retire_err);
      end
      for (int it = 0; it < 20; it++) begin
         aid = exp_free[0];
         rv  = (pend.size() >= 3);
         rid = rv ? pend.pop_front() : 0;
         drive(1'b1, rv, rid);
         pend.push_back(aid);
      end
      while (pend.size() > 0) drive(1'b0, 1'b1, pend.pop_front());
      tests_run++;
      if (bus.retire_err !== 1'b0 || bus.inflight_count !== 4'd0 || bus.idle !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_end: got err=%b count=%0d idle=%b, required 0/0/1", bus.retire_err, bus.inflight_count, bus.idle);
      end
      tests_run++;
      if (exp_free.size() != MAX_IDS || bus.alloc_id !== ID_W'(exp_free[0])) begin
         tests_failed++;
         $display("FAIL wrap_head: got head=%0d, required %0d", bus.alloc_id, exp_free[0]);
      end
      tests_run++;
      if (issue_q.size() != 0 || retire_q.size() != 0) begin
         tests_failed++;
         $display("FAIL wrap_queues: got %0d issue / %0d retire pending, required 0/0", issue_q.size(), retire_q.size());
      end
   endtask

   initial begin
      bus.flush        = 1'b0;
      bus.alloc_take   = 1'b0;
      bus.retire_valid = 1'b0;
      bus.retire_id    = '0;
      test_reset();
      test_fill();
      test_retire_empty();
      test_simultaneous();
      test_flush();
      test_wrap();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
